// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive front-end with a show-ahead receive FIFO.
//
// rx is synchronized, oversampled 16x per bit (tick period = max(os_div,2) clk),
// majority-voted over oversample ticks 7/8/9, and deframed (5..8 data bits,
// optional parity, 1 or 2 stop bits). Each frame is pushed as
// {data, perr, ferr} into a DEPTH-entry FIFO.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   rx                        asynchronous serial input, idle high
//   os_div                    clk cycles per oversample tick
//   length, parity_en,        frame format, latched at the start-bit edge
//   parity_type, stop2
//   m_data/m_perr/m_ferr      head entry (zero when empty)
//   m_valid, m_ready          read handshake
//   fifo_count                entries held
//   overflow                  sticky: a frame was dropped because the FIFO was full
//
// Read handshake: m_valid is high whenever the FIFO holds an entry and the head
// is presented on m_data/m_perr/m_ferr; an entry is consumed on every clk edge
// where m_valid && m_ready. m_ready while m_valid=0 has no effect.
//
// FSM state is the internal 'state' vector, encoded
// IDLE=0 START=1 DATA=2 PARITY=3 STOP1=4 STOP2=5.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic [15:0]   os_div,
  input  logic [3:0]    length,
  input  logic          parity_en,
  input  logic          parity_type,
  input  logic          stop2,
  output logic [7:0]    m_data,
  output logic          m_perr,
  output logic          m_ferr,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  logic [2:0]  state, state_nx;
  logic        rx_m, rx_s;
  logic [15:0] div_cnt, div_max;
  logic        tick;
  logic [3:0]  os_cnt;
  logic        s7, s8, maj, decide, bit_end;
  logic        armed, trigger;
  logic [3:0]  len_q;
  logic        par_en_q, par_type_q, stop2_q;
  logic [7:0]  data_q;
  logic [2:0]  bit_cnt;
  logic        last_bit;
  logic        par_acc, perr_q, ferr_q;
  logic        frame_done, ferr_fin;
  logic        push_q;
  logic [7:0]  push_data;
  logic        push_perr, push_ferr;

  // Two-flop synchronizer, preset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // >= rather than == so a divisor lowered mid-count still wraps promptly.
  assign div_max = (os_div < 16'd2) ? 16'd1 : os_div - 16'd1;
  assign tick    = (div_cnt >= div_max);
  assign trigger = (state == IDLE) && armed && !rx_s;

  // Restarting both counters at the start edge puts tick 8 near mid-bit.
  always_ff @(posedge clk) begin
    if (rst || trigger) begin
      div_cnt <= 16'd0;
      os_cnt  <= 4'd0;
    end else begin
      div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
      if (tick) os_cnt <= os_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s7 <= 1'b1;
      s8 <= 1'b1;
    end else if (tick && os_cnt == 4'd7) begin
      s7 <= rx_s;
    end else if (tick && os_cnt == 4'd8) begin
      s8 <= rx_s;
    end
  end

  assign maj      = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign decide   = tick && (os_cnt == 4'd9);
  assign bit_end  = tick && (os_cnt == 4'd15);
  assign last_bit = ((len_q - 4'd1) == {1'b0, bit_cnt});

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (trigger) state_nx = START;
      START:  if (decide && maj) state_nx = IDLE;
              else if (bit_end) state_nx = DATA;
      DATA:   if (bit_end && last_bit) state_nx = par_en_q ? PARITY : STOP1;
      PARITY: if (bit_end) state_nx = STOP1;
      STOP1:  if (stop2_q) begin
                if (bit_end) state_nx = STOP2;
              end else if (decide) begin
                state_nx = IDLE;
              end
      STOP2:  if (decide) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs (frame completion and its final framing flag)
  always_comb begin
    frame_done = decide && (((state == STOP1) && !stop2_q) || (state == STOP2));
    ferr_fin   = ~maj | ((state == STOP2) & ferr_q);
  end

  // Frame datapath. armed only sets while idle with the line high, so a
  // held-low break yields one frame and then waits for the line to recover.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed      <= 1'b0;
      len_q      <= 4'd8;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q    <= 1'b0;
      data_q     <= 8'd0;
      bit_cnt    <= 3'd0;
      par_acc    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      push_q     <= 1'b0;
      push_data  <= 8'd0;
      push_perr  <= 1'b0;
      push_ferr  <= 1'b0;
    end else begin
      push_q <= frame_done;
      if (frame_done) begin
        push_data <= data_q;
        push_perr <= perr_q;
        push_ferr <= ferr_fin;
      end
      if (trigger) armed <= 1'b0;
      else if (state == IDLE && rx_s) armed <= 1'b1;
      if (trigger) begin
        len_q      <= (length >= 4'd5 && length <= 4'd8) ? length : 4'd8;
        par_en_q   <= parity_en;
        par_type_q <= parity_type;
        stop2_q    <= stop2;
        data_q     <= 8'd0;
        bit_cnt    <= 3'd0;
        par_acc    <= 1'b0;
        perr_q     <= 1'b0;
        ferr_q     <= 1'b0;
      end
      if (state == DATA && decide) begin
        data_q[bit_cnt] <= maj;
        par_acc         <= par_acc ^ maj;
      end
      if (state == DATA && bit_end) bit_cnt <= last_bit ? 3'd0 : bit_cnt + 3'd1;
      if (state == PARITY && decide) perr_q <= (maj != (par_type_q ? par_acc : ~par_acc));
      if (state == STOP1 && decide) ferr_q <= ~maj;
    end
  end

  // Show-ahead FIFO
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, pop, wr_en;

  assign full  = (count == CW'(DEPTH));
  assign pop   = m_valid && m_ready;
  // When full, a push is only accepted if the head leaves in the same cycle.
  assign wr_en = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr] <= {push_data, push_perr, push_ferr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      if (push_q && full && !pop) overflow <= 1'b1;
    end
  end

  assign m_valid    = (count != '0);
  assign fifo_count = count;
  assign m_data     = m_valid ? mem[rd_ptr][9:2] : 8'd0;
  assign m_perr     = m_valid ? mem[rd_ptr][1]   : 1'b0;
  assign m_ferr     = m_valid ? mem[rd_ptr][0]   : 1'b0;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Single-clock UART receive front-end that is the far end of the team's UART transmitter.
- Derives 16x oversampling ticks from the system clock with a programmable divisor.
- Deserialises 5–8 bit frames using majority-vote sampling, with optional parity and 1 or 2 stop bits.
- Buffers received bytes and their error flags in a show-ahead FIFO with a valid/ready read port, for host-side or bus-side consumers.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- CW, 4, width of fifo_count; must hold the value DEPTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- rx  in  1  serial line, asynchronous, idle high.
- os_div  in  16  clk cycles per oversample tick; 16 ticks make one bit.
- length  in  4  data bits per frame, 5..8.
- parity_en  in  1  parity bit present.
- parity_type  in  1  1: parity = XOR of data bits; 0: parity = XNOR of data bits.
- stop2  in  1  two stop bits.
- m_data  out  8  head byte, right-aligned, unused upper bits 0.
- m_perr  out  1  parity error flag of head entry.
- m_ferr  out  1  framing error flag of head entry.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer pops head when m_valid && m_ready.
- fifo_count  out  CW  entries held.
- overflow  out  1  sticky: a frame was dropped.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: m_data=0, m_perr=0, m_ferr=0, m_valid=0, fifo_count=0, overflow=0. The FSM goes to IDLE and the synchronizer flops are preset to 1.
- Reset mid-frame abandons the frame; no partial entry is written.
- rx passes through a 2-flop synchronizer; all logic below uses the synchronized rx_s.
- Tick generator: counter 0..D-1, where D = max(os_div, 2); tick pulses for one clk when counter == D-1. The counter is free-running and resets to 0 on leaving IDLE.
- Config inputs (length, parity_en, parity_type, stop2) are latched on the start-bit falling edge and held for the whole frame.
- length outside 5..8 is treated as 8.
- Per bit: an oversample counter runs 0..15. rx_s is sampled at ticks 7, 8 and 9; the bit value is the majority of the three samples, decided on tick 9.
- FSM states:
  - IDLE: wait for armed && rx_s==0. "armed" sets once rx_s==1 has been seen in IDLE, which blocks re-triggering during a held-low break. On trigger, go to START.
  - START: at the tick-9 decision, a majority of 1 means a glitch; return to IDLE with nothing written. Otherwise continue, and on tick 15 go to DATA.
  - DATA: shift LSB first, length bits; bit_count wraps to 0. Then go to PARITY if parity_en, else STOP1.
  - PARITY: perr = (sampled != computed parity over the received bits).
  - STOP1: ferr = (sampled == 0).
    - stop2=0: at the tick-9 decision, push and return to IDLE. Returning at mid-stop allows resync to a back-to-back start edge.
    - stop2=1: at tick 15 go to STOP2.
  - STOP2: ferr |= (sampled == 0); at the tick-9 decision, push and return to IDLE.
- Push: {data, perr, ferr} is written on the clk after the final decision. m_valid rises the following clk if the FIFO was empty (decision to m_valid = 2 clk).
- Full handling: a push with fifo_count==DEPTH and no simultaneous pop is dropped, overflow is set, and contents are unchanged. A push and pop in the same cycle when full are both accepted.
- Pop: with m_valid && m_ready, the head advances; m_data, m_perr and m_ferr show the next entry on the following clk.
- Pop and push in the same cycle leave fifo_count unchanged. Read/write pointers wrap modulo DEPTH.
- A pop with m_valid=0 is ignored.
- Break (rx low for the entire frame): one entry is pushed with data=0 and ferr=1. No further frames are received until rx_s returns high.

Test Plan:
- os_div=4, length=8, no parity, stop2=0; send 0xA5 -> one entry: m_data=0xA5, m_perr=0, m_ferr=0, fifo_count=1; m_valid rises 2 clk after the stop-bit tick-9 decision.
- length=5, parity_en=1, parity_type=1; send data 0x15 with parity bit 0 -> m_data=0x15, m_perr=1. Resend with parity bit 1 -> m_perr=0.
- rx pulsed low for 5 ticks then high -> no entry, fifo_count stays 0, FSM back in IDLE. stop2=1 with second stop=0 -> m_ferr=1.
- DEPTH=8, m_ready=0, 9 frames 0x01..0x09 -> fifo_count=8, overflow=1. Then m_ready=1 -> pops 0x01..0x08 in order, m_valid drops, overflow stays 1.
- FIFO full and push coincident with pop -> fifo_count stays 8, new byte is retained at the tail, overflow stays 0.
- Assert rst during DATA of 0x3C, then send 0x5A -> only 0x5A is received. Separately, hold rx low for 3 frame times -> exactly one entry with 0x00 and ferr=1.
